tick_generator: RTL and testbench

//  Multi-channel programmable tick generator for periodic/one-shot timing pulses (1 Hz heartbeat, UART baud ticks, timeouts).

---
 rtl/tick_gen_pkg.sv | 16 +
 rtl/tick_channel.sv | 85 ++++++++
 rtl/tick_generator.sv | 50 +++++
 tb/tb_tick_generator.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package tick_gen_pkg;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } mode_e;

   // Widest period the legality check accepts; callers zero-extend into it.
   localparam int unsigned MAX_PERIOD_W = 64;

   function automatic logic period_legal(input logic [MAX_PERIOD_W-1:0] period);
      return period != '0;
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One timer channel: holds period, mode, down-counter and one-shot arm flag.
module tick_channel
   import tick_gen_pkg::*;
#(
   parameter int unsigned WIDTH          = 24,
   parameter int unsigned DEFAULT_PERIOD = 12000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_cfg_we,
   input  logic [WIDTH-1:0] i_cfg_period,
   input  mode_e            i_cfg_mode,
   input  logic             i_enable,
   input  logic             i_start,
   output logic             o_tick,
   output logic             o_busy
);

   logic [WIDTH-1:0] r_period;
   mode_e            r_mode;
   logic [WIDTH-1:0] r_count;
   logic             r_armed;
   logic             r_tick;
   logic             r_busy;

   logic [WIDTH-1:0] w_period;
   mode_e            w_mode;
   logic [WIDTH-1:0] w_reload;
   logic             w_run;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_armed_nxt;
   logic             w_tick_nxt;
   logic             w_busy_nxt;

   // A write landing on the same edge as a start/reload takes effect immediately.
   always_comb begin
      w_period    = i_cfg_we ? i_cfg_period : r_period;
      w_mode      = i_cfg_we ? i_cfg_mode : r_mode;
      w_reload    = w_period - WIDTH'(1);
      w_run       = i_enable && ((w_mode == MODE_PERIODIC) || r_armed);
      w_count_nxt = r_count;
      w_armed_nxt = r_armed;
      w_tick_nxt  = 1'b0;
      if (i_start) begin
         w_count_nxt = w_reload;
         w_armed_nxt = (w_mode == MODE_ONESHOT);
      end else if (w_run) begin
         if (r_count == '0) begin
            w_count_nxt = w_reload;
            w_tick_nxt  = 1'b1;
            w_armed_nxt = 1'b0;
         end else begin
            w_count_nxt = r_count - WIDTH'(1);
         end
      end
      // Arm flag is meaningless in periodic mode; keep it clear so a later
      // switch to one-shot idles until the next start.
      if (w_mode == MODE_PERIODIC) begin
         w_armed_nxt = 1'b0;
      end
      w_busy_nxt = (w_mode == MODE_PERIODIC) ? i_enable : w_armed_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_period <= WIDTH'(DEFAULT_PERIOD);
         r_mode   <= MODE_PERIODIC;
         r_count  <= WIDTH'(DEFAULT_PERIOD - 1);
         r_armed  <= 1'b0;
         r_tick   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_period <= w_period;
         r_mode   <= w_mode;
         r_count  <= w_count_nxt;
         r_armed  <= w_armed_nxt;
         r_tick   <= w_tick_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign o_tick = r_tick;
   assign o_busy = r_busy;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator: config decode plus one tick_channel per channel.
module tick_generator
   import tick_gen_pkg::*;
#(
   parameter int unsigned CHANNELS       = 2,
   parameter int unsigned WIDTH          = 24,
   parameter int unsigned DEFAULT_PERIOD = 12000000,
   localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_period,
   input  logic                cfg_oneshot,
   input  logic [CHANNELS-1:0] enable,
   input  logic [CHANNELS-1:0] start,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] busy
);

   logic                w_cfg_ok;
   mode_e               w_cfg_mode;
   logic [CHANNELS-1:0] w_ch_we;

   assign w_cfg_ok   = cfg_we
                       && period_legal(MAX_PERIOD_W'(cfg_period))
                       && (32'(cfg_ch) < 32'(CHANNELS));
   assign w_cfg_mode = mode_e'(cfg_oneshot);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      assign w_ch_we[g] = w_cfg_ok && (cfg_ch == CH_W'(g));

      tick_channel #(
         .WIDTH          (WIDTH),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_channel (
         .clk          (clk),
         .reset        (reset),
         .i_cfg_we     (w_ch_we[g]),
         .i_cfg_period (cfg_period),
         .i_cfg_mode   (w_cfg_mode),
         .i_enable     (enable[g]),
         .i_start      (start[g]),
         .o_tick       (tick[g]),
         .o_busy       (busy[g])
      );
   end

endmodule

// File: tb/tb_tick_generator.sv
// Directed self-checking bench for tick_generator (3 channels, reset period 5).
module tb_tick_generator;

   localparam int unsigned CHANNELS = 3;
   localparam int unsigned WIDTH    = 24;

   logic                clk = 1'b0;
   logic                reset;
   logic                cfg_we;
   logic [1:0]          cfg_ch;
   logic [WIDTH-1:0]    cfg_period;
   logic                cfg_oneshot;
   logic [CHANNELS-1:0] enable;
   logic [CHANNELS-1:0] start;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] busy;

   int n_checks = 0;
   int n_errors = 0;

   tick_generator #(
      .CHANNELS       (CHANNELS),
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .enable      (enable),
      .start       (start),
      .tick        (tick),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // n cycles; channel ch ticks at cycle 'first' (0 = never), then every 'per' (0 = once).
   task automatic run_cycles(input int n, input int ch, input int first, input int per);
      logic [CHANNELS-1:0] exp;
      for (int i = 1; i <= n; i++) begin
         step();
         exp = '0;
         if (first > 0 && (i == first || (per > 0 && i > first && (i - first) % per == 0)))
            exp[ch] = 1'b1;
         check_val($sformatf("tick ch%0d c%0d", ch, i), 32'(tick), 32'(exp));
      end
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [WIDTH-1:0] p, input logic os);
      cfg_we      = 1'b1;
      cfg_ch      = ch;
      cfg_period  = p;
      cfg_oneshot = os;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
      enable = '0; start = '0;
      step(); step();
      check_val("reset tick", 32'(tick), 32'(0));
      check_val("reset busy", 32'(busy), 32'(0));

      // Periodic from reset release, P=5
      reset = 1'b0; enable = 3'b001;
      run_cycles(15, 0, 5, 5);
      check_val("busy periodic", 32'(busy), 32'(3'b001));

      // Pause for 4 cycles mid-count (count=2 at pause)
      run_cycles(2, 0, 0, 0);
      enable = 3'b000;
      run_cycles(4, 0, 0, 0);
      check_val("busy paused", 32'(busy), 32'(0));
      enable = 3'b001;
      run_cycles(7, 0, 3, 5);
      check_val("busy resumed", 32'(busy), 32'(3'b001));

      // Start on count==0: no tick, full reload
      start = 3'b001;
      step();
      check_val("start wins", 32'(tick), 32'(0));
      start = '0;
      run_cycles(5, 0, 5, 0);

      // Period 2 written at count 3: old boundary, then every 2
      step();
      check_val("pre-write", 32'(tick), 32'(0));
      cfg_write(2'd0, 24'd2, 1'b0);
      step();
      check_val("write edge", 32'(tick), 32'(0));
      cfg_we = 1'b0;
      run_cycles(8, 0, 3, 2);

      // Illegal writes (period 0, out-of-range channel) are ignored
      cfg_write(2'd0, 24'd0, 1'b1);
      step();
      check_val("illegal p0 edge", 32'(tick), 32'(3'b001));
      cfg_write(2'd3, 24'd7, 1'b1);
      step();
      check_val("illegal ch edge", 32'(tick), 32'(0));
      cfg_we = 1'b0;
      run_cycles(6, 0, 1, 2);

      // ch1 one-shot P=3: mode change alone idles
      enable = 3'b010;
      cfg_write(2'd1, 24'd3, 1'b1);
      step();
      cfg_we = 1'b0;
      check_val("oneshot cfg tick", 32'(tick), 32'(0));
      check_val("oneshot cfg busy", 32'(busy), 32'(0));
      run_cycles(3, 1, 0, 0);
      start = 3'b010;
      step();
      start = '0;
      check_val("oneshot arm tick", 32'(tick), 32'(0));
      check_val("oneshot arm busy", 32'(busy), 32'(3'b010));
      run_cycles(3, 1, 3, 0);
      check_val("oneshot done busy", 32'(busy), 32'(0));
      run_cycles(6, 1, 0, 0);
      check_val("oneshot idle busy", 32'(busy), 32'(0));

      // Reset mid one-shot
      start = 3'b010;
      step();
      start = '0;
      step();
      check_val("mid oneshot busy", 32'(busy), 32'(3'b010));
      reset = 1'b1;
      step();
      check_val("reset mid tick", 32'(tick), 32'(0));
      check_val("reset mid busy", 32'(busy), 32'(0));
      reset = 1'b0;
      run_cycles(10, 1, 5, 5);
      check_val("default periodic busy", 32'(busy), 32'(3'b010));

      // ch2 P=1 written together with start: tick every enabled cycle
      enable = 3'b100; start = 3'b100;
      cfg_write(2'd2, 24'd1, 1'b0);
      step();
      start = '0; cfg_we = 1'b0;
      check_val("p1 start edge", 32'(tick), 32'(0));
      run_cycles(4, 2, 1, 1);
      check_val("p1 busy", 32'(busy), 32'(3'b100));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
